// File: rtl/serial_adder_pkg.sv
// -----------------------------------------------------------------------------
// serial_adder_pkg
// Purpose : Shared definitions for the bit-serial arithmetic blocks
//           (serial_adder now, serial_subtractor later).
// Contents: FSM state encoding, majority-of-three helper.
// Ports   : none (package).
// -----------------------------------------------------------------------------
package serial_adder_pkg;

  // ST_DONE names a state encoding only; it is unrelated to the done output.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Carry generation of a full adder: true when at least two inputs are set.
  function automatic logic maj3(input logic x, input logic y, input logic z);
    return (x & y) | (x & z) | (y & z);
  endfunction

endpackage

// File: rtl/serial_adder_full_adder.sv
// -----------------------------------------------------------------------------
// full_adder
// Purpose : One-bit combinational full adder, the per-bit cell of serial_adder.
//           Port naming mirrors the existing one-bit full subtractor.
// Ports   : A, B, Cin (in)  - operand bits and carry-in
//           sum, Cout (out) - sum bit and carry-out
// -----------------------------------------------------------------------------
module full_adder
  import serial_adder_pkg::*;
(
  input  logic A,
  input  logic B,
  input  logic Cin,
  output logic sum,
  output logic Cout
);

  assign sum  = A ^ B ^ Cin;
  assign Cout = maj3(A, B, Cin);

endmodule

// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
// Purpose : Bit-serial ripple adder. Computes a + b + cin one bit per clock,
//           LSB first, through a single full-adder cell and a carry flop.
//           A result takes WIDTH shift cycles plus one DONE cycle.
// Params  : WIDTH - operand/sum width, 2..32.
// Ports   : clk   (in)  rising-edge clock
//           rst_n (in)  synchronous active-low reset
//           start (in)  request an addition, honoured only while idle
//           a, b  (in)  WIDTH-bit addends, captured on accepted start
//           cin   (in)  carry-in, captured on accepted start
//           busy  (out) high while bits are being processed
//           done  (out) one-cycle pulse, sum/cout valid
//           sum   (out) (a + b + cin) mod 2^WIDTH, held until next result
//           cout  (out) carry-out of the MSB, held until next result
// -----------------------------------------------------------------------------
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int             CW       = $clog2(WIDTH);
  localparam logic [CW-1:0]  LAST_BIT = CW'(WIDTH - 1);

  state_e           r_state;
  state_e           w_next_state;

  logic [WIDTH-1:0] r_a_sr;
  logic [WIDTH-1:0] r_b_sr;
  logic [WIDTH-1:0] r_sum_sr;
  logic             r_carry;
  logic [CW-1:0]    r_count;

  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;

  logic             w_s;
  logic             w_c;
  logic             w_last;
  logic             w_busy_nxt;
  logic             w_done_nxt;

  // Single per-bit cell fed by the LSBs of the operand shifters and the carry.
  full_adder u_fa (
    .A    (r_a_sr[0]),
    .B    (r_b_sr[0]),
    .Cin  (r_carry),
    .sum  (w_s),
    .Cout (w_c)
  );

  assign w_last = (r_count == LAST_BIT);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic; start is only looked at while idle.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_next_state = ST_SHIFT;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (w_last) begin
          w_next_state = ST_DONE;
        end else begin
          w_next_state = ST_SHIFT;
        end
      end
      ST_DONE: w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Output decode from the upcoming state, so the registered flags line up
  // exactly with the state they describe.
  always_comb begin
    w_busy_nxt = 1'b0;
    w_done_nxt = 1'b0;
    case (w_next_state)
      ST_SHIFT: w_busy_nxt = 1'b1;
      ST_DONE:  w_done_nxt = 1'b1;
      default: begin
        w_busy_nxt = 1'b0;
        w_done_nxt = 1'b0;
      end
    endcase
  end

  // Output registers; the result is captured on the edge that enters DONE,
  // taking the final sum bit and carry straight from the cell.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_sum  <= '0;
      r_cout <= 1'b0;
    end else begin
      r_busy <= w_busy_nxt;
      r_done <= w_done_nxt;
      if ((r_state == ST_SHIFT) && w_last) begin
        r_sum  <= {w_s, r_sum_sr[WIDTH-1:1]};
        r_cout <= w_c;
      end
    end
  end

  // Operand/sum shifters, carry flop and bit counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a_sr   <= '0;
      r_b_sr   <= '0;
      r_sum_sr <= '0;
      r_carry  <= 1'b0;
      r_count  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_a_sr  <= a;
            r_b_sr  <= b;
            r_carry <= cin;
            r_count <= '0;
          end
        end
        ST_SHIFT: begin
          r_a_sr   <= {1'b0, r_a_sr[WIDTH-1:1]};
          r_b_sr   <= {1'b0, r_b_sr[WIDTH-1:1]};
          r_sum_sr <= {w_s, r_sum_sr[WIDTH-1:1]};
          r_carry  <= w_c;
          // Counter leaves SHIFT at WIDTH-1, so it never needs to wrap.
          r_count  <= r_count + 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign sum  = r_sum;
  assign cout = r_cout;

endmodule

// File: tb/tb_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_serial_adder
// Purpose : Self-checking bench for serial_adder. Two instances (WIDTH=8 and
//           WIDTH=3) are checked every cycle against a transaction-level model
//           (accept -> WIDTH busy cycles -> done with a+b+cin), plus literal
//           expectations for the directed cases.
// -----------------------------------------------------------------------------
module tb_serial_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       s8, c8, busy8, done8, cout8;
  logic [7:0] a8, b8, sum8;
  logic       s3, c3, busy3, done3, cout3;
  logic [2:0] a3, b3, sum3;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(s8), .a(a8), .b(b8), .cin(c8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );

  serial_adder #(.WIDTH(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(s3), .a(a3), .b(b3), .cin(c3),
    .busy(busy3), .done(done3), .sum(sum3), .cout(cout3)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: t < 0 idle, 0..w-1 busy, t == w done cycle; result is plain a+b+cin.
  typedef struct packed {
    logic signed [31:0] t;
    logic [63:0]        res;
    logic [31:0]        es;
    logic               ec;
  } mdl_t;

  mdl_t m8, m3;

  function automatic mdl_t step(input mdl_t m, input int w, input logic rn, input logic st,
                                input logic [31:0] ai, input logic [31:0] bi, input logic ci);
    mdl_t n = m;
    if (!rn) begin
      n.t = -1; n.es = 32'd0; n.ec = 1'b0;
    end else if (m.t < 0) begin
      if (st === 1'b1) begin
        n.t   = 0;
        n.res = 64'(ai) + 64'(bi) + 64'(ci);
      end
    end else if (m.t < w) begin
      n.t = m.t + 1;
      if (n.t == w) begin
        n.es = 32'(n.res & ((64'd1 << w) - 64'd1));
        n.ec = n.res[w];
      end
    end else begin
      n.t = -1;
    end
    return n;
  endfunction

  always @(posedge clk) begin
    m8 <= step(m8, 8, rst_n, s8, 32'(a8), 32'(b8), c8);
    m3 <= step(m3, 3, rst_n, s3, 32'(a3), 32'(b3), c3);
  end

  // Every-cycle comparison of both DUTs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("busy8", 32'(busy8), 32'(m8.t >= 0 && m8.t < 8));
      check("done8", 32'(done8), 32'(m8.t == 8));
      check("sum8",  32'(sum8),  m8.es);
      check("cout8", 32'(cout8), 32'(m8.ec));
      check("busy3", 32'(busy3), 32'(m3.t >= 0 && m3.t < 3));
      check("done3", 32'(done3), 32'(m3.t == 3));
      check("sum3",  32'(sum3),  m3.es);
      check("cout3", 32'(cout3), 32'(m3.ec));
    end
  end

  task automatic add8(input logic [7:0] a, input logic [7:0] b, input logic c,
                      input logic [7:0] es, input logic ec, input string name);
    int n;
    int nbusy;
    @(negedge clk);
    s8 = 1'b1; a8 = a; b8 = b; c8 = c;
    @(negedge clk);
    s8 = 1'b0;
    n = 1;
    nbusy = 0;
    while (done8 !== 1'b1 && n <= 30) begin
      if (busy8 === 1'b1) nbusy++;
      @(negedge clk);
      n++;
    end
    check({name, "_latency"}, 32'(n), 32'd9);
    check({name, "_busycycles"}, 32'(nbusy), 32'd8);
    check({name, "_sum"}, 32'(sum8), 32'(es));
    check({name, "_cout"}, 32'(cout8), 32'(ec));
    check({name, "_model"}, m8.es, 32'(es));
  endtask

  initial begin
    logic [8:0] r9;
    logic [7:0] ra, rb;
    logic       rc;
    logic [6:0] v;
    logic [3:0] exp4;
    int         n;
    int         ndone;

    rst_n = 1'b0;
    s8 = 1'b0; a8 = 8'h00; b8 = 8'h00; c8 = 1'b0;
    s3 = 1'b0; a3 = 3'h0;  b3 = 3'h0;  c3 = 1'b0;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    check("rst_busy", 32'(busy8), 32'd0);
    check("rst_done", 32'(done8), 32'd0);
    check("rst_sum",  32'(sum8),  32'd0);
    check("rst_cout", 32'(cout8), 32'd0);
    rst_n = 1'b1;

    // Directed additions.
    add8(8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0, "t1");
    add8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, "t2a");
    add8(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, "t2b");

    // start re-asserted mid-operation and held through DONE.
    @(negedge clk); s8 = 1'b1; a8 = 8'h10; b8 = 8'h20; c8 = 1'b0;
    @(negedge clk); s8 = 1'b0;
    @(negedge clk);
    @(negedge clk); s8 = 1'b1; a8 = 8'hAA; b8 = 8'h55;
    n = 0;
    while (done8 !== 1'b1 && n < 30) begin @(negedge clk); n++; end
    check("t3_first_sum", 32'(sum8), 32'h30);
    check("t3_first_cout", 32'(cout8), 32'd0);
    @(negedge clk);
    check("t3_single_done", 32'(done8), 32'd0);
    @(negedge clk); s8 = 1'b0;
    check("t3_reaccept", 32'(busy8), 32'd1);
    n = 0;
    while (done8 !== 1'b1 && n < 30) begin @(negedge clk); n++; end
    check("t3_second_sum", 32'(sum8), 32'hFF);

    // Reset in the middle of an addition.
    @(negedge clk); s8 = 1'b1; a8 = 8'h0F; b8 = 8'h01;
    @(negedge clk); s8 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk);
    check("t4_busy", 32'(busy8), 32'd0);
    check("t4_done", 32'(done8), 32'd0);
    check("t4_sum",  32'(sum8),  32'd0);
    check("t4_cout", 32'(cout8), 32'd0);
    rst_n = 1'b1;
    ndone = 0;
    repeat (15) begin
      @(negedge clk);
      if (done8 === 1'b1) ndone++;
    end
    check("t4_no_done", 32'(ndone), 32'd0);
    add8(8'h02, 8'h03, 1'b0, 8'h05, 1'b0, "t4_after");

    // Hold: operands wiggle with start low, outputs must stay put.
    repeat (20) begin
      @(negedge clk);
      a8 = 8'($urandom); b8 = 8'($urandom); c8 = 1'($urandom);
      check("hold_sum",  32'(sum8),  32'h05);
      check("hold_cout", 32'(cout8), 32'd0);
      check("hold_busy", 32'(busy8), 32'd0);
      check("hold_done", 32'(done8), 32'd0);
    end

    // Random additions on the 8-bit instance.
    repeat (24) begin
      ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
      r9 = {1'b0, ra} + {1'b0, rb} + {8'd0, rc};
      add8(ra, rb, rc, r9[7:0], r9[8], "rnd");
    end

    // Exhaustive WIDTH=3, start held high so each idle cycle takes the next op.
    @(negedge clk);
    v = 7'd0;
    s3 = 1'b1; a3 = v[6:4]; b3 = v[3:1]; c3 = v[0];
    exp4 = {1'b0, v[6:4]} + {1'b0, v[3:1]} + {3'd0, v[0]};
    for (int k = 0; k < 128; k++) begin
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (done3 !== 1'b1 && n < 40);
      check("x3_latency", 32'(n), (k == 0) ? 32'd4 : 32'd5);
      check("x3_result", 32'({cout3, sum3}), 32'(exp4));
      if (k < 127) begin
        v = 7'(k + 1);
        a3 = v[6:4]; b3 = v[3:1]; c3 = v[0];
        exp4 = {1'b0, v[6:4]} + {1'b0, v[3:1]} + {3'd0, v[0]};
      end else begin
        s3 = 1'b0;
      end
    end

    repeat (4) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial ripple adder; the additive counterpart of the team's one-bit full subtractor.
- Adds two WIDTH-bit operands plus a carry-in, one bit per clock, LSB first.
- A single carry flip-flop chains the bits through one full-adder cell.
- Used where area matters more than latency, and as a sequential reference for the arithmetic test benches.

Parameters:
- WIDTH, 8, operand and sum width in bits; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous, active-low reset.
- start  input  1  request a new addition; sampled only in IDLE.
- a  input  WIDTH  addend A; captured on the accepted start.
- b  input  WIDTH  addend B; captured on the accepted start.
- cin  input  1  carry-in; captured on the accepted start.
- busy  output  1  high while bits are being processed.
- done  output  1  one-cycle pulse; sum and cout are valid.
- sum  output  WIDTH  result (a + b + cin) mod 2^WIDTH.
- cout  output  1  carry-out of the MSB.

Behaviour:
- Reset: when rst_n is sampled low at a rising edge:
  - state = IDLE.
  - busy = 0, done = 0, sum = 0, cout = 0.
  - Operand shift registers, carry register and bit counter are cleared.
  - Reset mid-operation aborts the addition; no done pulse is produced.
- States: IDLE, SHIFT, DONE, encoded in 2 bits.
- IDLE:
  - If start = 1 at an edge: latch a, b; carry <= cin; count <= 0; go to SHIFT.
  - Otherwise hold. sum and cout keep their last result.
- SHIFT: busy = 1. Each cycle:
  - Compute s = a_sr[0] ^ b_sr[0] ^ carry, and c = majority(a_sr[0], b_sr[0], carry).
  - Shift a_sr and b_sr right by one.
  - sum_sr <= {s, sum_sr[WIDTH-1:1]}; carry <= c; count <= count + 1.
  - When count == WIDTH-1, the final bit is processed this cycle; go to DONE.
- DONE: busy = 0, done = 1 for exactly one cycle.
  - sum = sum_sr; cout = carry. Both are registered on entry to DONE.
  - Unconditionally return to IDLE. start is ignored in this cycle.
- Latency: if start is accepted at edge k, busy = 1 from k+1 to k+WIDTH, and done = 1 in cycle k+WIDTH+1. Throughput is one result per WIDTH+2 cycles.
- start while busy or in DONE: ignored. The in-flight operation and the latched operands are unaffected.
- Changes on a, b or cin after acceptance have no effect.
- sum and cout hold their values from the DONE cycle until the next DONE or reset.
- Overflow: wrap-around modulo 2^WIDTH; the carry appears only on cout. No saturation.
- Counter width: $clog2(WIDTH); it must not overflow for WIDTH = 32.
- No combinational path from inputs to outputs; all outputs are registered.

Decomposition:
- Shared package / include file: state encodings (ST_IDLE = 2'd0, ST_SHIFT = 2'd1, ST_DONE = 2'd2).
  - ST_DONE is a plain state-encoding localparam, not the done output; the two are distinct signals.
  - This file is reused by the planned serial_subtractor.
- One sub-module: full_adder.
  - Ports: A, B, Cin in; sum, Cout out.
  - Purely combinational; instantiated once as the per-bit cell.
  - Its port naming mirrors the existing full subtractor for symmetry.

Test Plan:
- WIDTH=8, a=8'h35, b=8'h4A, cin=0, start pulsed at cycle 0:
  - busy high in cycles 1..8.
  - done high only in cycle 9, with sum=8'h7F, cout=0.
- WIDTH=8, a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1. Then a=8'hFF, b=8'hFF, cin=1 -> sum=8'hFF, cout=1.
- WIDTH=8, a=8'h10, b=8'h20 started:
  - start pulsed again in cycle 3 with a=8'hAA, b=8'h55, and held high through DONE.
  - Expected: only one done, sum=8'h30.
  - A new start in the following IDLE cycle yields sum=8'hFF.
- WIDTH=8, a=8'h0F, b=8'h01 started; rst_n driven low at cycle 4:
  - Next edge: busy=0, done=0, sum=0, cout=0.
  - No done pulse follows.
  - A subsequent start with a=8'h02, b=8'h03 gives sum=8'h05.
- WIDTH=3, exhaustive: all 128 combinations of {a, b, cin}, issued back-to-back with start asserted in each IDLE.
  - For each, {cout, sum} must equal a+b+cin.
  - Each done must arrive WIDTH+1 = 4 cycles after its start edge.
- Hold check: after a completed add, toggle a, b, cin for 20 cycles with start=0 -> sum, cout, busy and done remain unchanged.
